// File: rtl/pong_vga_render_if.sv
// Coordinate bus between the Nios system and the Pong VGA renderer.
//   master : software side, drives the six 10-bit coordinates, samples busy
//   slave  : renderer side, samples the coordinates, drives busy
// Signals:
//   bx, by     ball top-left corner
//   p1x, p1y   paddle 1 top-left corner
//   p2x, p2y   paddle 2 top-left corner
//   busy       high while the renderer is scanning visible lines
interface pong_vga_render_if;
  logic [9:0] bx;
  logic [9:0] by;
  logic [9:0] p1x;
  logic [9:0] p1y;
  logic [9:0] p2x;
  logic [9:0] p2y;
  logic       busy;

  modport master (output bx, by, p1x, p1y, p2x, p2y, input busy);
  modport slave  (input bx, by, p1x, p1y, p2x, p2y, output busy);
endinterface

// File: rtl/pong_vga_render.sv
// Pong VGA renderer: generates 640x480@60 timing from the system clock and
// paints the ball and two paddles from coordinates written by software.
// Coordinates are shadow-latched on the last pixel of each frame, so a frame
// never mixes old and new positions.
// Ports:
//   clk_clk      system clock (pixel tick every CLK_DIV clocks)
//   reset_reset  asynchronous reset, active-high
//   pos          coordinate bus (slave): bx/by/p1x/p1y/p2x/p2y in, busy out
//   vga_hs       horizontal sync, active-low
//   vga_vs       vertical sync, active-low
//   vga_blank_n  high during visible pixels
//   vga_r/g/b    4-bit colour channels
// Build option:
//   PONG_NET_EN  when defined, draws a dashed grey centre net below the paddles
module pong_vga_render #(
  parameter int CLK_DIV   = 2,
  parameter int H_ACTIVE  = 640,
  parameter int H_FP      = 16,
  parameter int H_SYNC    = 96,
  parameter int H_BP      = 48,
  parameter int V_ACTIVE  = 480,
  parameter int V_FP      = 10,
  parameter int V_SYNC    = 2,
  parameter int V_BP      = 33,
  parameter int BALL_SIZE = 8,
  parameter int PAD_W     = 8,
  parameter int PAD_H     = 48
) (
  input  logic                    clk_clk,
  input  logic                    reset_reset,
  pong_vga_render_if.slave        pos,
  output logic                    vga_hs,
  output logic                    vga_vs,
  output logic                    vga_blank_n,
  output logic [3:0]              vga_r,
  output logic [3:0]              vga_g,
  output logic [3:0]              vga_b
);

  localparam int H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int HS_START = H_ACTIVE + H_FP;
  localparam int HS_END   = HS_START + H_SYNC;
  localparam int VS_START = V_ACTIVE + V_FP;
  localparam int VS_END   = VS_START + V_SYNC;
  localparam int DW       = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  // Pixel-rate divider
  logic [DW-1:0] div;
  logic          tick;

  assign tick = (div == DW'(CLK_DIV - 1));

  always_ff @(posedge clk_clk or posedge reset_reset) begin
    if (reset_reset)  div <= '0;
    else if (tick)    div <= '0;
    else              div <= div + 1'b1;
  end

  // Raster counters
  logic [9:0] hcnt, vcnt;
  logic [9:0] hcnt_nxt, vcnt_nxt;
  logic       h_last, v_last;

  assign h_last = (hcnt == 10'(H_TOTAL - 1));
  assign v_last = (vcnt == 10'(V_TOTAL - 1));

  always_comb begin
    hcnt_nxt = hcnt + 10'd1;
    vcnt_nxt = vcnt;
    if (h_last) begin
      hcnt_nxt = '0;
      vcnt_nxt = v_last ? 10'd0 : vcnt + 10'd1;
    end
  end

  always_ff @(posedge clk_clk or posedge reset_reset) begin
    if (reset_reset) begin
      hcnt <= '0;
      vcnt <= '0;
    end else if (tick) begin
      hcnt <= hcnt_nxt;
      vcnt <= vcnt_nxt;
    end
  end

  // Shadow coordinates, captured on the final pixel of the frame so the
  // whole next frame is painted from one consistent set.
  logic [9:0] sbx, sby, sp1x, sp1y, sp2x, sp2y;

  always_ff @(posedge clk_clk or posedge reset_reset) begin
    if (reset_reset) begin
      sbx  <= '0;
      sby  <= '0;
      sp1x <= '0;
      sp1y <= '0;
      sp2x <= '0;
      sp2y <= '0;
    end else if (tick && h_last && v_last) begin
      sbx  <= pos.bx;
      sby  <= pos.by;
      sp1x <= pos.p1x;
      sp1y <= pos.p1y;
      sp2x <= pos.p2x;
      sp2y <= pos.p2y;
    end
  end

  // Box test in 11 bits so x+size can never wrap back onto the left/top edge.
  function automatic logic in_box(input logic [9:0]  x0,
                                  input logic [9:0]  y0,
                                  input logic [10:0] w,
                                  input logic [10:0] ht,
                                  input logic [10:0] px,
                                  input logic [10:0] py);
    logic [10:0] x11, y11;
    x11 = {1'b0, x0};
    y11 = {1'b0, y0};
    return (px >= x11) && (px < x11 + w) && (py >= y11) && (py < y11 + ht);
  endfunction

  logic [10:0] h11, v11;
  logic        visible, hs_on, vs_on;
  logic        ball_on, pad1_on, pad2_on;
  logic [11:0] rgb_nxt;

  assign h11     = {1'b0, hcnt};
  assign v11     = {1'b0, vcnt};
  assign visible = (hcnt < 10'(H_ACTIVE)) && (vcnt < 10'(V_ACTIVE));
  assign hs_on   = (hcnt >= 10'(HS_START)) && (hcnt < 10'(HS_END));
  assign vs_on   = (vcnt >= 10'(VS_START)) && (vcnt < 10'(VS_END));
  assign ball_on = in_box(sbx,  sby,  11'(BALL_SIZE), 11'(BALL_SIZE), h11, v11);
  assign pad1_on = in_box(sp1x, sp1y, 11'(PAD_W),     11'(PAD_H),     h11, v11);
  assign pad2_on = in_box(sp2x, sp2y, 11'(PAD_W),     11'(PAD_H),     h11, v11);

`ifdef PONG_NET_EN
  logic net_on;
  // 4-pixel-wide centre stripe, dashed every 16 lines
  assign net_on = (hcnt >= 10'(H_ACTIVE / 2 - 2)) && (hcnt <= 10'(H_ACTIVE / 2 + 1)) && !vcnt[4];
`endif

  always_comb begin
    rgb_nxt = 12'h000;
    if (visible) begin
      if (ball_on)      rgb_nxt = 12'hFFF;
      else if (pad1_on) rgb_nxt = 12'hF00;
      else if (pad2_on) rgb_nxt = 12'h00F;
`ifdef PONG_NET_EN
      else if (net_on)  rgb_nxt = 12'h888;
`endif
    end
  end

  // Single output stage: sync, blank, colour and busy share one register
  // so they stay aligned one tick behind the counters.
  always_ff @(posedge clk_clk or posedge reset_reset) begin
    if (reset_reset) begin
      vga_hs      <= 1'b1;
      vga_vs      <= 1'b1;
      vga_blank_n <= 1'b0;
      vga_r       <= '0;
      vga_g       <= '0;
      vga_b       <= '0;
      pos.busy    <= 1'b1;
    end else if (tick) begin
      vga_hs      <= !hs_on;
      vga_vs      <= !vs_on;
      vga_blank_n <= visible;
      vga_r       <= rgb_nxt[11:8];
      vga_g       <= rgb_nxt[7:4];
      vga_b       <= rgb_nxt[3:0];
      // Based on the next line number so busy drops together with vcnt reaching V_ACTIVE
      pos.busy    <= (vcnt_nxt < 10'(V_ACTIVE));
    end
  end

endmodule

// File: tb/tb_pong_vga_render.sv
module tb_pong_vga_render;
  localparam int CLK_DIV = 2;
  localparam int HA = 64, HFP = 2, HSY = 4, HBP = 2;
  localparam int VA = 48, VFP = 1, VSY = 2, VBP = 1;
  localparam int HT = HA + HFP + HSY + HBP;
  localparam int VT = VA + VFP + VSY + VBP;
  localparam int NONE_MIN = 9999;
`ifdef PONG_NET_EN
  localparam int EXP_NET = 128;
`else
  localparam int EXP_NET = 0;
`endif

  logic       clk, rst;
  logic       vga_hs, vga_vs, vga_blank_n;
  logic [3:0] vga_r, vga_g, vga_b;

  pong_vga_render_if pos();

  pong_vga_render #(
    .CLK_DIV(CLK_DIV), .H_ACTIVE(HA), .H_FP(HFP), .H_SYNC(HSY), .H_BP(HBP),
    .V_ACTIVE(VA), .V_FP(VFP), .V_SYNC(VSY), .V_BP(VBP),
    .BALL_SIZE(8), .PAD_W(8), .PAD_H(48)
  ) dut (
    .clk_clk(clk), .reset_reset(rst), .pos(pos),
    .vga_hs(vga_hs), .vga_vs(vga_vs), .vga_blank_n(vga_blank_n),
    .vga_r(vga_r), .vga_g(vga_g), .vga_b(vga_b)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    int w, r, b, g, o;
    int wx0, wx1, wy0, wy1, bx0;
    int hs_lo, vs_lo, blank_hi, busy_hi;
  } fstat_t;

  typedef struct {
    int bx, by, p1x, p1y, p2x, p2y;
    int w, r, b;
    int wx0, wx1, wy0, wy1, bx0;
  } vec_t;

  fstat_t fs [16];
  fstat_t cur;
  int frame_no   = 0;
  int mon_h      = 0;
  int mon_v      = 0;
  int timing_err = 0;
  int stable_err = 0;
  int errors     = 0;
  int checks     = 0;

  function automatic fstat_t empty_stat();
    fstat_t s;
    s = '{default: 0};
    s.wx0 = NONE_MIN;
    s.wy0 = NONE_MIN;
    s.bx0 = NONE_MIN;
    s.wx1 = -1;
    s.wy1 = -1;
    return s;
  endfunction

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Raster monitor: follows the pixel tick independently and tallies each frame.
  initial begin
    int         tdiv;
    logic [18:0] cur_out, prev_out, rst_out;
    logic [11:0] rgb;
    logic        eh, ev, eb, ebusy;
    int          nv;
    rst_out  = {1'b1, 1'b1, 1'b0, 12'h000, 1'b1};
    prev_out = rst_out;
    tdiv     = 0;
    cur      = empty_stat();
    forever begin
      @(negedge clk);
      if (rst) begin
        tdiv     = 0;
        mon_h    = 0;
        mon_v    = 0;
        cur      = empty_stat();
        prev_out = rst_out;
      end else begin
        rgb     = {vga_r, vga_g, vga_b};
        cur_out = {vga_hs, vga_vs, vga_blank_n, rgb, pos.busy};
        if (tdiv == CLK_DIV - 1) begin
          tdiv  = 0;
          eh    = !(mon_h >= HA + HFP && mon_h < HA + HFP + HSY);
          ev    = !(mon_v >= VA + VFP && mon_v < VA + VFP + VSY);
          eb    = (mon_h < HA) && (mon_v < VA);
          nv    = (mon_h == HT - 1) ? ((mon_v == VT - 1) ? 0 : mon_v + 1) : mon_v;
          ebusy = (nv < VA);
          if (vga_hs !== eh || vga_vs !== ev || vga_blank_n !== eb ||
              pos.busy !== ebusy || (!eb && rgb != 12'h000))
            timing_err++;
          if (!vga_hs)     cur.hs_lo++;
          if (!vga_vs)     cur.vs_lo++;
          if (vga_blank_n) cur.blank_hi++;
          if (pos.busy)    cur.busy_hi++;
          case (rgb)
            12'hFFF: begin
              cur.w++;
              if (mon_h < cur.wx0) cur.wx0 = mon_h;
              if (mon_h > cur.wx1) cur.wx1 = mon_h;
              if (mon_v < cur.wy0) cur.wy0 = mon_v;
              if (mon_v > cur.wy1) cur.wy1 = mon_v;
            end
            12'hF00: cur.r++;
            12'h00F: begin
              cur.b++;
              if (mon_h < cur.bx0) cur.bx0 = mon_h;
            end
            12'h888: cur.g++;
            12'h000: ;
            default: cur.o++;
          endcase
          if (mon_h == HT - 1 && mon_v == VT - 1) begin
            if (frame_no < 16) fs[frame_no] = cur;
            frame_no++;
            cur = empty_stat();
          end
          if (mon_h == HT - 1) begin
            mon_h = 0;
            mon_v = (mon_v == VT - 1) ? 0 : mon_v + 1;
          end else begin
            mon_h++;
          end
        end else begin
          tdiv++;
          if (cur_out !== prev_out) stable_err++;
        end
        prev_out = cur_out;
      end
    end
  end

  task automatic wait_frame(input int target);
    int n;
    n = 0;
    while (frame_no < target && n < 2 * HT * VT * CLK_DIV) begin
      @(negedge clk);
      n++;
    end
    check($sformatf("wait_frame_%0d", target), frame_no, target);
  endtask

  task automatic wait_line(input int line);
    int n;
    n = 0;
    while (mon_v != line && n < 2 * HT * VT * CLK_DIV) begin
      @(negedge clk);
      n++;
    end
    check($sformatf("wait_line_%0d", line), mon_v, line);
  endtask

  task automatic apply(input vec_t v);
    pos.bx  = 10'(v.bx);
    pos.by  = 10'(v.by);
    pos.p1x = 10'(v.p1x);
    pos.p1y = 10'(v.p1y);
    pos.p2x = 10'(v.p2x);
    pos.p2y = 10'(v.p2y);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_hs"},    int'(vga_hs), 1);
    check({tag, "_vs"},    int'(vga_vs), 1);
    check({tag, "_blank"}, int'(vga_blank_n), 0);
    check({tag, "_rgb"},   int'({vga_r, vga_g, vga_b}), 0);
    check({tag, "_busy"},  int'(pos.busy), 1);
  endtask

  task automatic check_objects(input int f, input vec_t v);
    string t;
    t = $sformatf("f%0d", f);
    check({t, "_white"}, fs[f].w,   v.w);
    check({t, "_red"},   fs[f].r,   v.r);
    check({t, "_blue"},  fs[f].b,   v.b);
    check({t, "_other"}, fs[f].o,   0);
    check({t, "_wx0"},   fs[f].wx0, v.wx0);
    check({t, "_wx1"},   fs[f].wx1, v.wx1);
    check({t, "_wy0"},   fs[f].wy0, v.wy0);
    check({t, "_wy1"},   fs[f].wy1, v.wy1);
    check({t, "_bx0"},   fs[f].bx0, v.bx0);
  endtask

  task automatic check_timing_counts(input int f);
    string t;
    t = $sformatf("f%0d", f);
    check({t, "_hs_low"},   fs[f].hs_lo,    HSY * VT);
    check({t, "_vs_low"},   fs[f].vs_lo,    VSY * HT);
    check({t, "_blank_hi"}, fs[f].blank_hi, HA * VA);
    check({t, "_busy_hi"},  fs[f].busy_hi,  HA * 0 + HT * VA);
    check({t, "_net"},      fs[f].g,        EXP_NET);
  endtask

  vec_t vecs [6];
  vec_t zero_frame;
  vec_t torn;

  initial begin
    // bx, by, p1x, p1y, p2x, p2y | white, red, blue | white box x0,x1,y0,y1 | blue x0
    vecs[0] = '{20,   10,   0,    0,  0,  0,  64, 384,   0, 20, 27, 10, 17, NONE_MIN};
    vecs[1] = '{4,    4,    0,    0,  30, 0,  64, 352, 384,  4, 11,  4, 11, 30};
    vecs[2] = '{200,  0,    1000, 0,  60, 44,  0,   0,  16, NONE_MIN, -1, NONE_MIN, -1, 60};
    vecs[3] = '{62,   46,   10,   40, 40, 10,  4,  64, 304, 62, 63, 46, 47, 40};
    vecs[4] = '{1023, 1023, 20,   0,  24, 0,   0, 384, 192, NONE_MIN, -1, NONE_MIN, -1, 28};
    vecs[5] = '{20,   10,   0,    0,  50, 0,  64, 384, 384, 20, 27, 10, 17, 50};
    zero_frame = '{0, 0, 0, 0, 0, 0, 64, 320, 0, 0, 7, 0, 7, NONE_MIN};
    torn       = '{40, 10, 0, 0, 50, 0, 64, 384, 384, 40, 47, 10, 17, 50};

    rst = 1'b1;
    apply('{default: 0});
    repeat (4) @(negedge clk);
    #1;
    check_reset_outputs("por");
    rst = 1'b0;

    // Each vector is written during frame k and must appear in frame k+1.
    for (int k = 0; k < 6; k++) begin
      apply(vecs[k]);
      wait_frame(k + 1);
    end

    // Frame 6 shows vecs[5]; moving the ball mid-frame must not tear it.
    wait_line(20);
    pos.bx = 10'd40;
    wait_frame(7);
    wait_frame(8);

    // Mid-frame reset during frame 8.
    wait_line(30);
    #1 rst = 1'b1;
    #1;
    check_reset_outputs("midrst");
    repeat (3) @(negedge clk);
    #1 rst = 1'b0;
    wait_frame(9);

    check_objects(0, zero_frame);
    check_timing_counts(0);
    for (int k = 0; k < 6; k++) check_objects(k + 1, vecs[k]);
    check_timing_counts(1);
    check_objects(7, torn);
    check_objects(8, zero_frame);
    check_timing_counts(8);
    check("timing_model", timing_err, 0);
    check("hold_between_ticks", stable_err, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/pong_vga_render.md
Name: pong_vga_render

Overview:
- Downstream of the Nios system. Consumes the ball and paddle coordinates the software writes (bx, by, p1x, p1y, p2x, p2y, 10-bit each).
- Generates 640x480@60 VGA timing and paints the ball and both paddles.
- Drives the system's busy input high during active video. Software then writes new positions only during vertical blanking.
- Positions are shadow-latched once per frame, so no frame ever shows a mix of old and new coordinates (no tearing).

Parameters:
- CLK_DIV, 2, system clocks per pixel; pixel tick is a 1-cycle pulse every CLK_DIV clocks.
- H_ACTIVE, 640, visible pixels per line.
- H_FP, 16, horizontal front porch, in ticks.
- H_SYNC, 96, horizontal sync width, in ticks.
- H_BP, 48, horizontal back porch, in ticks.
- V_ACTIVE, 480, visible lines.
- V_FP, 10, vertical front porch, in lines.
- V_SYNC, 2, vertical sync width, in lines.
- V_BP, 33, vertical back porch, in lines.
- BALL_SIZE, 8, ball edge length, in pixels.
- PAD_W, 8, paddle width, in pixels.
- PAD_H, 48, paddle height, in pixels.

Ports:
- clk_clk  in  1  system clock, 50 MHz.
- reset_reset  in  1  asynchronous reset, active-high.
- bx  in  10  ball left x.
- by  in  10  ball top y.
- p1x  in  10  paddle 1 left x.
- p1y  in  10  paddle 1 top y.
- p2x  in  10  paddle 2 left x.
- p2y  in  10  paddle 2 top y.
- busy  out  1  high while the vertical counter is in the active region; connects to busy_export.
- vga_hs  out  1  horizontal sync, active-low.
- vga_vs  out  1  vertical sync, active-low.
- vga_blank_n  out  1  high during visible pixels.
- vga_r  out  4  red.
- vga_g  out  4  green.
- vga_b  out  4  blue.

Behaviour:
- Reset: all counters 0; shadow positions 0; vga_hs=1; vga_vs=1; vga_blank_n=0; rgb=0; busy=1.
- Reset is honoured mid-line or mid-frame. Timing restarts at h=0, v=0 on the first tick after release.
- Pixel tick: a divider counts 0..CLK_DIV-1 and pulses tick on wrap. All counters and outputs advance only on tick.
- hcnt runs 0..H_TOTAL-1, where H_TOTAL = sum of the H parameters (800). It wraps to 0.
- vcnt increments when hcnt wraps. It runs 0..V_TOTAL-1, where V_TOTAL = 525, then wraps.
- Sync active regions:
  - hsync when H_ACTIVE+H_FP <= hcnt < H_ACTIVE+H_FP+H_SYNC.
  - vsync when V_ACTIVE+V_FP <= vcnt < V_ACTIVE+V_FP+V_SYNC.
- busy: registered; busy = (vcnt < V_ACTIVE), updated on tick. It falls on the tick where vcnt becomes V_ACTIVE and rises when vcnt wraps to 0.
- Shadow latch: all six coordinate inputs are captured on the tick where hcnt=H_TOTAL-1 and vcnt=V_TOTAL-1. They are used for the whole following frame. Input changes at any other time have no visible effect until the next latch.
- Hit tests compare against the shadow values in 11-bit arithmetic, so x+size never wraps:
  - ball: sbx <= hcnt < sbx+BALL_SIZE and sby <= vcnt < sby+BALL_SIZE.
  - paddle 1: sp1x <= hcnt < sp1x+PAD_W and sp1y <= vcnt < sp1y+PAD_H.
  - paddle 2: same form with sp2x, sp2y.
- Clipping: coordinates >= the active size, or objects running past the right/bottom edge, are simply clipped. No error, no wrap to the left or top.
- Colour priority: ball F/F/F (white) > paddle 1 F/0/0 (red) > paddle 2 0/0/F (blue) > net (optional feature) > background 0/0/0.
- Outside the visible area: rgb=0 and vga_blank_n=0.
- Latency: 1 tick from counter state to registered outputs. hs, vs and blank_n are registered in the same stage, so all outputs stay mutually aligned.
- Overlapping objects resolve by priority only.

Optional Feature:
- Macro PONG_NET_EN.
- Defined: a centre net at hcnt in [H_ACTIVE/2-2, H_ACTIVE/2+1] is drawn only where vcnt[4]=0 (16-line dashes), colour 8/8/8. Priority is below the paddles.
- Undefined: no net logic; those pixels show the background.

Test Plan:
- Reset release, run 2 frames: hs low for 96 ticks per 800; vs low for 2 lines per 525; tick every 2 clk; first hs falling edge at hcnt=656.
- Busy framing: busy=1 for vcnt 0..479; busy falls within 1 tick of vcnt becoming 480; busy rises at vcnt wrap.
- bx=100, by=50, others 0: white pixels exactly at x 100..107, y 50..57 (64 pixels). Paddle 1 at 0..7 x 0..47 shows red except where the ball overlaps.
- Tearing: change bx 100->300 at vcnt=200. The current frame still draws the ball at 100; the next frame draws it at 300.
- Clip: p2x=636, p2y=470: blue only at x 636..639, y 470..479; nothing at x 0..3.
- Reset asserted mid-frame at vcnt=300: outputs immediately take reset values; after release, the frame restarts at vcnt=0 with busy=1. With PONG_NET_EN, gray pixels appear at x 318..321, rows 0..15 and 32..47.
